// File: rtl/regresp_tlp_tx.sv
// rtl/regresp_tlp_tx.sv - queued memory-write TLP transmitter for a TRN tx port
//
// Purpose: buffers host write requests in a small FIFO and turns each one into
// a PCIe MWr32/MWr64 TLP on a 64-bit TRN transmit interface, arbitrating for
// the shared endpoint port (req_ep/my_trn/drv_ep) and leaving a fixed idle
// gap after every packet.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake into the queue
//   req_addr, req_len_qw,    host byte address, payload quadwords (0 or too
//   req_data                 large means MAX_QW), payload DWs little-end first
//   cfg_completer_id         requester ID source (sampled one cycle late)
//   trn_td ... trn_tbuf_av   TRN transmit interface
//   my_trn, req_ep, drv_ep   endpoint arbiter grant/request/drive
//   q_level                  current queue occupancy
module regresp_tlp_tx #(
  parameter int         DEPTH  = 4,
  parameter int         MAX_QW = 4,
  parameter int         GAP    = 8,
  parameter logic [7:0] TAG    = 8'h00
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [63:0]             req_addr,
  input  logic [4:0]              req_len_qw,
  input  logic [64*MAX_QW-1:0]    req_data,
  input  logic [15:0]             cfg_completer_id,
  output logic [63:0]             trn_td,
  output logic [7:0]              trn_trem_n,
  output logic                    trn_tsof_n,
  output logic                    trn_teof_n,
  output logic                    trn_tsrc_rdy_n,
  input  logic                    trn_tdst_rdy_n,
  input  logic [3:0]              trn_tbuf_av,
  input  logic                    my_trn,
  output logic                    req_ep,
  output logic                    drv_ep,
  output logic [$clog2(DEPTH):0]  q_level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int DB = 64 * MAX_QW;
  localparam int GW = $clog2(GAP + 1);
  localparam logic [6:0] FMT_MWR32 = 7'b1000000;
  localparam logic [6:0] FMT_MWR64 = 7'b1100000;

  typedef struct packed {
    logic [63:0]   addr;
    logic [4:0]    len;
    logic [DB-1:0] data;
  } entry_t;

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_HDR, S_ADDR64, S_DATA, S_GAPW} state_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            rdy_q, rdy_d;
  state_t          state_q, state_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [4:0]      beat_q, beat_d;
  logic [15:0]     rid_q, rid_d;
  logic [63:0]     td_q, td_d;
  logic [7:0]      trem_n_q, trem_n_d;
  logic            tsof_n_q, tsof_n_d, teof_n_q, teof_n_d, tsrc_rdy_n_q, tsrc_rdy_n_d;
  logic            req_ep_q, req_ep_d, drv_ep_q, drv_ep_d;

  entry_t          head;
  logic            push, pop, accept, is64;
  logic [4:0]      eff_len, last_idx, sel_beat;
  logic [63:0]     nb_td;
  logic [7:0]      nb_trem_n;
  logic            nb_eof;
  int              k;
  logic            unused_tbuf;

  assign unused_tbuf = ^{trn_tbuf_av[3:2], trn_tbuf_av[0]};

  function automatic logic [31:0] swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Out-of-range indices read as zero so the pad DW of an MWr32 tail is harmless.
  function automatic logic [31:0] dw_at(input logic [DB-1:0] d, input int idx);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 2 * MAX_QW; i++) begin
      if (i == idx) r = d[32*i +: 32];
    end
    return r;
  endfunction

  assign head     = mem_q[rd_ptr_q];
  assign is64     = |head.addr[63:32];
  assign last_idx = head.len + 5'd1;
  assign accept   = !tsrc_rdy_n_q && !trn_tdst_rdy_n;
  assign push     = req_valid && rdy_q;
  assign eff_len  = (req_len_qw == 5'd0 || req_len_qw > 5'(MAX_QW)) ? 5'(MAX_QW) : req_len_qw;

  // Beat numbering is shared by both formats: 0 header, 1 address (MWr32 also
  // carries DW0 here), then len data beats. MWr32 data is shifted by one DW.
  always_comb begin
    sel_beat  = (state_q == S_ARB) ? 5'd0 : beat_q + 5'd1;
    k         = int'(sel_beat) - 2;
    nb_eof    = (sel_beat == last_idx);
    nb_td     = '0;
    if (sel_beat == 5'd0) begin
      nb_td = {1'b0, is64 ? FMT_MWR64 : FMT_MWR32, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0,
               2'b00, 2'b00, 4'b0000, head.len, 1'b0, rid_q, TAG, 4'hF, 4'hF};
    end else if (sel_beat == 5'd1) begin
      nb_td = is64 ? head.addr : {head.addr[31:0], swap(dw_at(head.data, 0))};
    end else if (is64) begin
      nb_td = {swap(dw_at(head.data, 2*k)), swap(dw_at(head.data, 2*k + 1))};
    end else begin
      nb_td = {swap(dw_at(head.data, 2*k + 1)), nb_eof ? 32'h0 : swap(dw_at(head.data, 2*k + 2))};
    end
    nb_trem_n = (nb_eof && !is64) ? 8'h0F : 8'h00;
  end

  always_comb begin
    state_d      = state_q;
    gap_d        = gap_q;
    beat_d       = beat_q;
    rid_d        = cfg_completer_id;
    td_d         = td_q;
    trem_n_d     = trem_n_q;
    tsof_n_d     = tsof_n_q;
    teof_n_d     = teof_n_q;
    tsrc_rdy_n_d = tsrc_rdy_n_q;
    req_ep_d     = req_ep_q;
    drv_ep_d     = drv_ep_q;
    pop          = 1'b0;
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;

    case (state_q)
      S_IDLE: begin
        if (level_q != '0) begin
          req_ep_d = 1'b1;
          state_d  = S_ARB;
        end
      end
      S_ARB: begin
        if (my_trn && trn_tbuf_av[1] && !trn_tdst_rdy_n) begin
          req_ep_d     = 1'b0;
          drv_ep_d     = 1'b1;
          td_d         = nb_td;
          trem_n_d     = nb_trem_n;
          tsof_n_d     = 1'b0;
          teof_n_d     = !nb_eof;
          tsrc_rdy_n_d = 1'b0;
          beat_d       = 5'd0;
          state_d      = S_HDR;
        end
      end
      S_HDR, S_ADDR64, S_DATA: begin
        if (accept) begin
          if (beat_q == last_idx) begin
            td_d         = '0;
            trem_n_d     = 8'hFF;
            tsof_n_d     = 1'b1;
            teof_n_d     = 1'b1;
            tsrc_rdy_n_d = 1'b1;
            drv_ep_d     = 1'b0;
            pop          = 1'b1;
            gap_d        = GW'(GAP);
            state_d      = S_GAPW;
          end else begin
            td_d     = nb_td;
            trem_n_d = nb_trem_n;
            tsof_n_d = 1'b1;
            teof_n_d = !nb_eof;
            beat_d   = beat_q + 5'd1;
            state_d  = (state_q == S_HDR && is64) ? S_ADDR64 : S_DATA;
          end
        end
      end
      S_GAPW: begin
        if (gap_q == '0) state_d = S_IDLE;
        else             gap_d   = gap_q - GW'(1);
      end
      default: state_d = S_GAPW;
    endcase

    if (push) begin
      mem_d[wr_ptr_q] = {req_addr, eff_len, req_data};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

    level_d = level_q;
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (!push && pop) level_d = level_q - LW'(1);
    rdy_d = (level_d < LW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_GAPW;
      gap_q        <= GW'(GAP);
      beat_q       <= '0;
      rid_q        <= '0;
      td_q         <= '0;
      trem_n_q     <= 8'hFF;
      tsof_n_q     <= 1'b1;
      teof_n_q     <= 1'b1;
      tsrc_rdy_n_q <= 1'b1;
      req_ep_q     <= 1'b0;
      drv_ep_q     <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      rdy_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      gap_q        <= gap_d;
      beat_q       <= beat_d;
      rid_q        <= rid_d;
      td_q         <= td_d;
      trem_n_q     <= trem_n_d;
      tsof_n_q     <= tsof_n_d;
      teof_n_q     <= teof_n_d;
      tsrc_rdy_n_q <= tsrc_rdy_n_d;
      req_ep_q     <= req_ep_d;
      drv_ep_q     <= drv_ep_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      rdy_q        <= rdy_d;
    end
  end

  // Queue storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign req_ready      = rdy_q;
  assign q_level        = level_q;
  assign trn_td         = td_q;
  assign trn_trem_n     = trem_n_q;
  assign trn_tsof_n     = tsof_n_q;
  assign trn_teof_n     = teof_n_q;
  assign trn_tsrc_rdy_n = tsrc_rdy_n_q;
  assign req_ep         = req_ep_q;
  assign drv_ep         = drv_ep_q;

endmodule
